// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle ARM-subset core: state control, ALU/immediate decode,
// NZCV flag register and condition gating. Define UNDEF_TRAP_EN to add the Undef output.
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
`ifdef UNDEF_TRAP_EN
  ,
  output logic       Undef
`endif
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t     state, next_state;
  logic       cond_ex, cond_ex_r;
  logic       ir_w, next_pc, regw, memw, aluop, branch, pcs;
  logic [3:0] cmd;
  logic       is_addsub;

  assign cmd       = Funct[4:1];
  assign is_addsub = (cmd == 4'b0100) || (cmd == 4'b0010);

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = Flags[2];
      4'b0001: cond_ex = ~Flags[2];
      4'b0010: cond_ex = Flags[1];
      4'b0011: cond_ex = ~Flags[1];
      4'b0100: cond_ex = Flags[3];
      4'b0101: cond_ex = ~Flags[3];
      4'b0110: cond_ex = Flags[0];
      4'b0111: cond_ex = ~Flags[0];
      4'b1000: cond_ex = ~Flags[2] & Flags[1];
      4'b1001: cond_ex = Flags[2] | ~Flags[1];
      4'b1010: cond_ex = ~(Flags[3] ^ Flags[0]);
      4'b1011: cond_ex = Flags[3] ^ Flags[0];
      4'b1100: cond_ex = ~Flags[2] & ~(Flags[3] ^ Flags[0]);
      4'b1101: cond_ex = Flags[2] | (Flags[3] ^ Flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= FETCH;
    else       state <= next_state;
  end

  // Condition is frozen at decode so the instruction's own flag update cannot gate itself.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cond_ex_r <= 1'b0;
      Flags     <= 4'b0000;
    end else begin
      if (state == DECODE) cond_ex_r <= cond_ex;
      if ((state == EXECR || state == EXECI) && cond_ex_r && Funct[0]) begin
        Flags[3:2] <= ALUFlags[3:2];
        if (is_addsub) Flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    ir_w       = 1'b0;
    next_pc    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    regw       = 1'b0;
    memw       = 1'b0;
    aluop      = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        ir_w = 1'b1; next_pc = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        next_state = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD:  begin AdrSrc = 1'b1; next_state = MEMWB; end
      MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; next_state = FETCH; end
      MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; next_state = FETCH; end
      EXECR:    begin aluop = 1'b1; ALUSrcB = 2'b00; next_state = ALUWB; end
      EXECI:    begin aluop = 1'b1; ALUSrcB = 2'b01; next_state = ALUWB; end
      ALUWB:    begin regw = 1'b1; next_state = FETCH; end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
        next_state = FETCH;
      end
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    if (aluop) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  // Write enables are masked by RSTn so an asynchronous reset kills them in the same cycle.
  assign pcs      = regw & (Rd == 4'd15);
  assign PCWrite  = RSTn & (next_pc | ((branch | pcs) & cond_ex_r));
  assign IRWrite  = RSTn & ir_w;
  assign RegWrite = RSTn & regw & cond_ex_r;
  assign MemWrite = RSTn & memw & cond_ex_r;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

`ifdef UNDEF_TRAP_EN
  assign Undef = (state == DECODE) && ((Cond == 4'b1111) || (Op == 2'b11));
`endif

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main controller for the multicycle ARM-subset processor. It sequences fetch, decode, execute, memory and writeback through a Moore state machine and decodes ALU and immediate controls. It holds the NZCV flags register, evaluates the instruction condition field against the stored flags, and gates every architectural write with the result. It sits between the instruction register (Cond/Op/Funct/Rd fields) and the datapath muxes and enables.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Cond  in  4  instruction[31:28].
- Op  in  2  instruction[27:26].
- Funct  in  6  instruction[25:20]: I, cmd[3:0], S/L.
- Rd  in  4  instruction[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  gated write enables.
- AdrSrc, ALUSrcA  out  1 each  mux selects.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each.
- Flags  out  4  stored {N,Z,C,V}.
- Undef  out  1  present only with UNDEF_TRAP_EN.

## Operation
- CondEx encoding (N,Z,C,V from Flags):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V.
  - 1000 ~Z&C; 1001 Z|~C; 1010 ~(N^V); 1011 N^V; 1100 ~Z&~(N^V); 1101 Z|(N^V).
  - 1110 always 1; 1111 always 0.
- States and Moore outputs (unlisted signals are 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECR; with Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH.
  - MEMADR: ALUSrcB=01. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, MemW=1. Next: FETCH.
  - EXECR: ALUOp=1, ALUSrcB=00. Next: ALUWB.
  - EXECI: ALUOp=1, ALUSrcB=01. Next: ALUWB.
  - ALUWB: RegW=1. Next: FETCH.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
- CondExR: CondEx latched on the edge that leaves DECODE. All gating uses CondExR, so flag updates made by the instruction itself cannot affect its own writes.
- Gating:
  - PCS = RegW & (Rd==15).
  - PCWrite = NextPC | ((Branch|PCS) & CondExR).
  - RegWrite = RegW & CondExR.
  - MemWrite = MemW & CondExR.
- ALUControl:
  - ALUOp=0: 00 (ADD).
  - ALUOp=1, decoded from cmd=Funct[4:1]: 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; any other cmd -> 00.
- Flag update:
  - Occurs on the edge leaving EXECR/EXECI, only if CondExR=1 and S=Funct[0]=1.
  - N,Z always load from ALUFlags.
  - C,V load only for ADD/SUB; otherwise they hold.
- Combinational decodes from Op: ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).

## Timing
- Reset (RSTn=0, asynchronous):
  - State=FETCH, Flags=0000, CondExR=0.
  - PCWrite, IRWrite, RegWrite, MemWrite forced 0 while RSTn=0, including reset asserted mid-instruction.
  - Mux outputs show FETCH values.
- First cycle after RSTn rises: FETCH with IRWrite=1, PCWrite=1.
- Cycle counts, FETCH to next FETCH:
  - Data-processing: 4.
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
  - Op=11: 2.
- A suppressed instruction (CondExR=0) still traverses all of its states; only its writes and flag update are suppressed.
- Flags changes are visible one cycle after the execute state.

## Configuration
- UNDEF_TRAP_EN defined:
  - Undef port exists.
  - Undef=1 in DECODE when Cond=1111 or Op=11; 0 otherwise.
  - Execution is suppressed by CondExR=0.
- UNDEF_TRAP_EN undefined:
  - No Undef port.
  - Cond=1111 is silently never-execute; Op=11 returns to FETCH with no trap indication.

## Test plan
- Reset: hold RSTn=0 for 3 cycles -> Flags=0000, all write enables 0. Release -> IRWrite=1, PCWrite=1 in the first cycle.
- ADD R-type, Funct=001000, Cond=1110, Rd=3 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR; Flags unchanged.
- SUBS, Funct=000101, ALUFlags=0110 -> Flags=0110 after EXECR. Then Op=10 with Cond=0000 -> PCWrite=1 in BRANCH. With Cond=0001 -> PCWrite=0.
- LDR, Op=01, Funct[0]=1 -> 5 states, RegWrite=1 in MEMWB. STR with Cond=0001 while Z=1 -> MemWrite stays 0, returns to FETCH after 4 cycles.
- ADD with Rd=15, Cond=1110 -> PCWrite=1 and RegWrite=1 in ALUWB. Reset asserted during MEMWRITE -> MemWrite drops to 0 immediately and state becomes FETCH.
- With UNDEF_TRAP_EN, Cond=1111 data-processing -> Undef=1 in DECODE, no RegWrite and no flag change.
